// File: rtl/parser_pkg.sv
// Shared definitions for the parser ingress path.
//   WORD_W           : width of one parser word
//   PARSER_MAX_WORDS : size of the parser output buffer, in words
//   arb_state_t      : ingress arbiter FSM states
package parser_pkg;

  localparam int WORD_W           = 32;
  localparam int PARSER_MAX_WORDS = 12;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_FWD   = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Scans req_i upward starting at ptr_i, wrapping at N, and returns the first
// requester found.
//   req_i     : request vector, one bit per source
//   ptr_i     : highest-priority index for this pick (must be < N)
//   gnt_oh_o  : one-hot grant (all zero when nothing requests)
//   gnt_idx_o : index of the granted source (0 when nothing requests)
//   any_o     : at least one request is set
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_oh_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          any_o
);

  // One spare bit so ptr + offset cannot overflow before the wrap.
  logic [IW:0]   sum;
  logic [IW-1:0] sel;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    sum       = '0;
    sel       = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr_i} + (IW + 1)'(i);
      // Subtractive wrap keeps non-power-of-2 N correct.
      if (sum >= (IW + 1)'(N)) begin
        sum = sum - (IW + 1)'(N);
      end
      sel = sum[IW-1:0];
      if (!any_o && req_i[sel]) begin
        any_o          = 1'b1;
        gnt_oh_o[sel]  = 1'b1;
        gnt_idx_o      = sel;
      end
    end
  end

endmodule

// File: rtl/parser_ingress_arbiter.sv
// Shares one packet parser between NUM_SRC ingress links, granting whole
// packets in round-robin order and forwarding words with no added latency.
// Packets longer than MAX_WORDS are truncated (par_last forced on the last
// forwarded word) and their remaining words are drained.
//
// Handshake: on every interface (src_* and par_*) a word moves on a cycle
// where val and ready are both 1; the sender holds data/val/last stable until
// that cycle. ready may depend combinationally on the other side's ready.
//
// Ports:
//   clk, reset_b  : clock, asynchronous active-low reset
//   src_data      : per-source words, source i at [32*i+31:32*i]
//   src_val       : per-source valid
//   src_last      : per-source last word of packet
//   src_ready     : per-source ready
//   par_data/val/last, par_ready : parser receive interface
//   grant_id      : current or most recent granted source
//   busy          : high while forwarding or draining
//   err_oversize  : one-cycle pulse after a packet was truncated
//   dbg_state     : FSM state (arb_state_t encoding)
module parser_ingress_arbiter
  import parser_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int MAX_WORDS = PARSER_MAX_WORDS
) (
  input  logic                        clk,
  input  logic                        reset_b,
  input  logic [NUM_SRC*WORD_W-1:0]   src_data,
  input  logic [NUM_SRC-1:0]          src_val,
  input  logic [NUM_SRC-1:0]          src_last,
  output logic [NUM_SRC-1:0]          src_ready,
  output logic [WORD_W-1:0]           par_data,
  output logic                        par_val,
  input  logic                        par_ready,
  output logic                        par_last,
  output logic [$clog2(NUM_SRC)-1:0]  grant_id,
  output logic                        busy,
  output logic                        err_oversize,
  output logic [1:0]                  dbg_state
);

  localparam int GW = $clog2(NUM_SRC);
  localparam int CW = $clog2(MAX_WORDS + 1);

  arb_state_t    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic [NUM_SRC-1:0] pick_oh;
  logic [GW-1:0]      pick_idx;
  logic               pick_any;

  rr_pick #(
    .N  (NUM_SRC),
    .IW (GW)
  ) u_rr_pick (
    .req_i     (src_val),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  // Signals of the currently granted source.
  logic              g_val;
  logic              g_last;
  logic [WORD_W-1:0] g_data;
  logic              at_limit;

  assign g_val    = src_val[grant_q];
  assign g_last   = src_last[grant_q];
  assign g_data   = src_data[WORD_W*int'(grant_q) +: WORD_W];
  // The word now presented would be the MAX_WORDS-th forwarded word.
  assign at_limit = (cnt_q == CW'(MAX_WORDS - 1));

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    src_ready = '0;
    par_val   = 1'b0;
    par_last  = 1'b0;
    par_data  = '0;

    unique case (state_q)
      ARB_IDLE: begin
        // Arbitration bubble: no word moves in this cycle.
        if (pick_any) begin
          grant_d  = pick_idx;
          rr_ptr_d = (pick_idx == GW'(NUM_SRC - 1)) ? '0 : pick_idx + GW'(1);
          cnt_d    = '0;
          state_d  = ARB_FWD;
        end
      end

      ARB_FWD: begin
        par_val            = g_val;
        par_last           = g_last | at_limit;
        par_data           = g_val ? g_data : '0;
        src_ready[grant_q] = par_ready;
        if (g_val && par_ready) begin
          if (cnt_q != CW'(MAX_WORDS)) begin
            cnt_d = cnt_q + CW'(1);
          end
          // A genuine last wins even when it lands exactly on the limit.
          if (g_last) begin
            state_d = ARB_IDLE;
          end else if (at_limit) begin
            err_d   = 1'b1;
            state_d = ARB_DRAIN;
          end
        end
      end

      ARB_DRAIN: begin
        // Swallow the rest of the truncated packet; parser sees nothing.
        src_ready[grant_q] = 1'b1;
        if (g_val && g_last) begin
          state_d = ARB_IDLE;
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign grant_id     = grant_q;
  assign busy         = (state_q != ARB_IDLE);
  assign err_oversize = err_q;
  assign dbg_state    = state_q;

endmodule
